// File: rtl/dmem_router_pkg.sv
// dmem_router_pkg: shared encodings for the data-side router.
//   chan_st_e   - per-channel handshake FSM states
//   err_cause_e - err_cause output encodings
//   RAM_BASE / CLINT_BASE - default decode values for addr[31:28]
//   cnt_width() - timeout counter width, clamped to 8..16 bits
package dmem_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_TOUT = 2'd2
  } chan_st_e;

  typedef enum logic [1:0] {
    EC_NONE  = 2'd0,
    EC_WMISS = 2'd1,
    EC_RMISS = 2'd2,
    EC_TOUT  = 2'd3
  } err_cause_e;

  localparam logic [3:0] RAM_BASE   = 4'h0;
  localparam logic [3:0] CLINT_BASE = 4'hC;

  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/dmem_router_chan.sv
// dmem_router_chan: one direction (read or write) of the data router.
//   Decodes the request address field to a slave, routes the request,
//   returns the selected slave's valid, answers decode misses at once and
//   forces a completion after TIMEOUT unanswered request cycles.
// Ports:
//   clk, resetb   clock, async active-low reset
//   req, dec      master request and addr[DEC_HI:DEC_LO]
//   s_valid       per-slave accept
//   s_ready       per-slave request (lowest matching index only)
//   m_valid       completion to the master (combinational)
//   fail          this cycle completes with an error (miss or timeout)
//   tout          this cycle is a forced timeout completion
//   hit_idx       decoded slave index, NSLV on miss
module dmem_router_chan
  import dmem_router_pkg::*;
#(
  parameter int NSLV    = 2,
  parameter int DW      = 4,
  parameter logic [NSLV*DW-1:0] SLV_BASE = {CLINT_BASE, RAM_BASE},
  parameter int TIMEOUT = 255,
  localparam int SW     = $clog2(NSLV + 1)
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            req,
  input  logic [DW-1:0]   dec,
  input  logic [NSLV-1:0] s_valid,
  output logic [NSLV-1:0] s_ready,
  output logic            m_valid,
  output logic            fail,
  output logic            tout,
  output logic [SW-1:0]   hit_idx
);

  localparam int CW = cnt_width(TIMEOUT);

  chan_st_e        state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [NSLV-1:0] hit_oh;
  logic            miss;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit_idx = SW'(NSLV);
    for (int i = NSLV - 1; i >= 0; i--)
      if (dec == SLV_BASE[i*DW +: DW]) hit_idx = SW'(i);
  end

  always_comb begin
    for (int i = 0; i < NSLV; i++) hit_oh[i] = (hit_idx == SW'(i));
  end

  assign miss    = (hit_idx == SW'(NSLV));
  assign tout    = (state == ST_TOUT);
  // No slave sees the request during the forced-completion cycle.
  assign s_ready = (req && !tout) ? hit_oh : '0;
  // On a miss hit_oh is zero, so only the router's own answer applies.
  assign m_valid = tout | (req & miss) | (|(s_valid & hit_oh));
  assign fail    = tout | (req & miss);
  assign cnt_nxt = cnt + 1'b1;

  // cnt counts request cycles already spent unanswered; when the current
  // one would make TIMEOUT, the next cycle is the forced completion.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_WAIT: begin
          if (!req || m_valid) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (TIMEOUT != 0 && cnt_nxt == CW'(TIMEOUT)) begin
            state <= ST_TOUT;
            cnt   <= '0;
          end else begin
            state <= ST_WAIT;
            cnt   <= (TIMEOUT != 0) ? cnt_nxt : '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_router.sv
// dmem_router: data-side interconnect between the core's split read/write
// data port and NSLV address-decoded slave ports.
//   m_w* / m_r*   master write / read channels (request=*ready, accept=*valid)
//   s_w* / s_r*   slave channels; address/data broadcast, ready/valid per slave
//   m_rdata/m_rresp  read return, valid the cycle after acceptance, muxed
//                    from a select register updated only on read acceptance
//   err           one-cycle pulse the cycle after a miss or timeout
//   err_addr/err_cause  last error info when DMEM_ROUTER_ERR_CAPTURE_EN is
//                       defined, otherwise constant zero
module dmem_router
  import dmem_router_pkg::*;
#(
  parameter int NSLV    = 2,
  parameter int DEC_HI  = 31,
  parameter int DEC_LO  = 28,
  parameter logic [NSLV*(DEC_HI-DEC_LO+1)-1:0] SLV_BASE = {CLINT_BASE, RAM_BASE},
  parameter int TIMEOUT = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               m_wready,
  output logic               m_wvalid,
  input  logic [31:0]        m_waddr,
  input  logic [31:0]        m_wdata,
  input  logic [3:0]         m_wstrb,
  input  logic               m_rready,
  output logic               m_rvalid,
  input  logic [31:0]        m_raddr,
  output logic               m_rresp,
  output logic [31:0]        m_rdata,
  output logic [NSLV-1:0]    s_wready,
  input  logic [NSLV-1:0]    s_wvalid,
  output logic [31:0]        s_waddr,
  output logic [31:0]        s_wdata,
  output logic [3:0]         s_wstrb,
  output logic [NSLV-1:0]    s_rready,
  input  logic [NSLV-1:0]    s_rvalid,
  output logic [31:0]        s_raddr,
  input  logic [NSLV-1:0]    s_rresp,
  input  logic [NSLV*32-1:0] s_rdata,
  output logic               err,
  output logic [31:0]        err_addr,
  output logic [1:0]         err_cause
);

  localparam int DW = DEC_HI - DEC_LO + 1;
  localparam int SW = $clog2(NSLV + 1);

  logic          w_fail, w_tout, r_fail, r_tout, r_acc;
  logic [SW-1:0] w_hit_unused, r_hit;
  logic [SW-1:0] rsel_q;
  logic          rerr_q;

  assign s_waddr = m_waddr;
  assign s_wdata = m_wdata;
  assign s_wstrb = m_wstrb;
  assign s_raddr = m_raddr;

  dmem_router_chan #(
    .NSLV(NSLV), .DW(DW), .SLV_BASE(SLV_BASE), .TIMEOUT(TIMEOUT)
  ) u_wchan (
    .clk     (clk),
    .resetb  (resetb),
    .req     (m_wready),
    .dec     (m_waddr[DEC_HI:DEC_LO]),
    .s_valid (s_wvalid),
    .s_ready (s_wready),
    .m_valid (m_wvalid),
    .fail    (w_fail),
    .tout    (w_tout),
    .hit_idx (w_hit_unused)
  );

  dmem_router_chan #(
    .NSLV(NSLV), .DW(DW), .SLV_BASE(SLV_BASE), .TIMEOUT(TIMEOUT)
  ) u_rchan (
    .clk     (clk),
    .resetb  (resetb),
    .req     (m_rready),
    .dec     (m_raddr[DEC_HI:DEC_LO]),
    .s_valid (s_rvalid),
    .s_ready (s_rready),
    .m_valid (m_rvalid),
    .fail    (r_fail),
    .tout    (r_tout),
    .hit_idx (r_hit)
  );

  assign r_acc = m_rready & m_rvalid;

  // Read-return select. rerr_q separates "last read completed with an error"
  // from "no read yet": both park rsel_q at NSLV, but only the former returns
  // ERR_DATA/rresp=0, so out of reset the return is 0/OK.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rsel_q <= SW'(NSLV);
      rerr_q <= 1'b0;
    end else if (r_acc) begin
      rsel_q <= r_fail ? SW'(NSLV) : r_hit;
      rerr_q <= r_fail;
    end
  end

  always_comb begin
    m_rdata = rerr_q ? ERR_DATA : 32'h0;
    m_rresp = ~rerr_q;
    for (int i = 0; i < NSLV; i++) begin
      if (rsel_q == SW'(i)) begin
        m_rdata = s_rdata[i*32 +: 32];
        m_rresp = s_rresp[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) err <= 1'b0;
    else         err <= w_fail | r_fail;
  end

`ifdef DMEM_ROUTER_ERR_CAPTURE_EN
  // Write error takes priority when both channels fail in the same cycle.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      err_addr  <= 32'h0;
      err_cause <= EC_NONE;
    end else if (w_fail) begin
      err_addr  <= m_waddr;
      err_cause <= w_tout ? EC_TOUT : EC_WMISS;
    end else if (r_fail) begin
      err_addr  <= m_raddr;
      err_cause <= r_tout ? EC_TOUT : EC_RMISS;
    end
  end
`else
  logic cap_unused;
  assign cap_unused = w_tout ^ r_tout;
  assign err_addr   = 32'h0;
  assign err_cause  = EC_NONE;
`endif

endmodule

// File: tb/tb_dmem_router.sv
module tb_dmem_router;

  localparam int NSLV    = 2;
  localparam int TIMEOUT = 4;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic              clk, resetb;
  logic              m_wready, m_wvalid, m_rready, m_rvalid, m_rresp;
  logic [31:0]       m_waddr, m_wdata, m_raddr, m_rdata;
  logic [3:0]        m_wstrb, s_wstrb;
  logic [NSLV-1:0]   s_wready, s_wvalid, s_rready, s_rvalid, s_rresp;
  logic [31:0]       s_waddr, s_wdata, s_raddr;
  logic [NSLV*32-1:0] s_rdata;
  logic              err;
  logic [31:0]       err_addr;
  logic [1:0]        err_cause;

  dmem_router #(
    .NSLV(NSLV), .DEC_HI(31), .DEC_LO(28), .SLV_BASE({4'hC, 4'h0}),
    .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
  ) dut (
    .clk(clk), .resetb(resetb),
    .m_wready(m_wready), .m_wvalid(m_wvalid), .m_waddr(m_waddr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rready(m_rready), .m_rvalid(m_rvalid), .m_raddr(m_raddr),
    .m_rresp(m_rresp), .m_rdata(m_rdata),
    .s_wready(s_wready), .s_wvalid(s_wvalid), .s_waddr(s_waddr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rready(s_rready), .s_rvalid(s_rvalid), .s_raddr(s_raddr),
    .s_rresp(s_rresp), .s_rdata(s_rdata),
    .err(err), .err_addr(err_addr), .err_cause(err_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: decode table plus transaction-level bookkeeping.
  logic [3:0]  base_tab [NSLV];
  int          w_wait, r_wait;     // unanswered request cycles so far
  bit          w_to, r_to;         // this cycle is a forced completion
  int          last_rd;            // -1 none, -2 error return, else slave
  bit          exp_err;
  logic [31:0] exp_eaddr;
  logic [1:0]  exp_ecause;
  bit          w_acc_last, r_acc_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NSLV; i++) if (a[31:28] == base_tab[i]) return i;
    return NSLV;
  endfunction

  function automatic void adv(input bit req, input bit acc, inout int wt, inout bit to);
    if (to) begin
      to = 0; wt = 0;
    end else if (!req || acc) begin
      wt = 0;
    end else begin
      wt++;
      if (TIMEOUT != 0 && wt == TIMEOUT) begin to = 1; wt = 0; end
    end
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    case ($urandom_range(0, 2))
      0:       a[31:28] = 4'h0;
      1:       a[31:28] = 4'hC;
      default: a[31:28] = 4'($urandom);
    endcase
    return a;
  endfunction

  function automatic void model_reset();
    w_wait = 0; r_wait = 0; w_to = 0; r_to = 0; last_rd = -1;
    exp_err = 0; exp_eaddr = 0; exp_ecause = 0;
    w_acc_last = 0; r_acc_last = 0;
  endfunction

  task automatic idle_inputs();
    m_wready = 0; m_waddr = 0; m_wdata = 0; m_wstrb = 0;
    m_rready = 0; m_raddr = 0;
    s_wvalid = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".m_wvalid"}, 32'(m_wvalid), 32'(0));
    chk({tag, ".m_rvalid"}, 32'(m_rvalid), 32'(0));
    chk({tag, ".m_rresp"},  32'(m_rresp),  32'(1));
    chk({tag, ".m_rdata"},  m_rdata,       32'h0);
    chk({tag, ".s_wready"}, 32'(s_wready), 32'(0));
    chk({tag, ".s_rready"}, 32'(s_rready), 32'(0));
    chk({tag, ".err"},      32'(err),      32'(0));
    chk({tag, ".err_addr"}, err_addr,      32'h0);
    chk({tag, ".err_cause"}, 32'(err_cause), 32'(0));
  endtask

  // One clock cycle: drive at negedge, compare #1 later, advance the model.
  task automatic step(input bit wr, input logic [31:0] wa, input bit rr, input logic [31:0] ra,
                      input logic [1:0] swv, input logic [1:0] srv,
                      input logic [63:0] rdat, input logic [1:0] rrsp);
    int wi, ri;
    bit ewv, erv, wf, rf;
    logic [NSLV-1:0] ewr, err_r;
    logic [31:0] xd;
    logic xr;
    @(negedge clk);
    m_wready = wr; m_waddr = wa; m_wdata = $urandom; m_wstrb = 4'($urandom);
    m_rready = rr; m_raddr = ra;
    s_wvalid = swv; s_rvalid = srv; s_rdata = rdat; s_rresp = rrsp;
    #1;
    wi = decode(wa); ri = decode(ra);
    ewr = '0; err_r = '0;
    if (w_to) ewv = 1;
    else if (wi == NSLV) ewv = wr;
    else begin ewv = swv[wi]; if (wr) ewr[wi] = 1'b1; end
    if (r_to) erv = 1;
    else if (ri == NSLV) erv = rr;
    else begin erv = srv[ri]; if (rr) err_r[ri] = 1'b1; end
    chk("m_wvalid", 32'(m_wvalid), 32'(ewv));
    chk("s_wready", 32'(s_wready), 32'(ewr));
    chk("m_rvalid", 32'(m_rvalid), 32'(erv));
    chk("s_rready", 32'(s_rready), 32'(err_r));
    chk("s_waddr",  s_waddr, wa);
    chk("s_wdata",  s_wdata, m_wdata);
    chk("s_wstrb",  32'(s_wstrb), 32'(m_wstrb));
    chk("s_raddr",  s_raddr, ra);
    if (last_rd == -1)      begin xd = 32'h0;    xr = 1'b1; end
    else if (last_rd == -2) begin xd = ERR_DATA; xr = 1'b0; end
    else begin xd = rdat[last_rd*32 +: 32]; xr = rrsp[last_rd]; end
    chk("m_rdata", m_rdata, xd);
    chk("m_rresp", 32'(m_rresp), 32'(xr));
    chk("err", 32'(err), 32'(exp_err));
`ifdef DMEM_ROUTER_ERR_CAPTURE_EN
    chk("err_addr",  err_addr, exp_eaddr);
    chk("err_cause", 32'(err_cause), 32'(exp_ecause));
`else
    chk("err_addr",  err_addr, 32'h0);
    chk("err_cause", 32'(err_cause), 32'(0));
`endif
    // Advance model to the state after the coming clock edge.
    wf = w_to || (wr && wi == NSLV);
    rf = r_to || (rr && ri == NSLV);
    exp_err = wf || rf;
    if (wf)      begin exp_eaddr = wa; exp_ecause = w_to ? 2'd3 : 2'd1; end
    else if (rf) begin exp_eaddr = ra; exp_ecause = r_to ? 2'd3 : 2'd2; end
    w_acc_last = wr && ewv;
    r_acc_last = rr && erv;
    if (r_acc_last) last_rd = rf ? -2 : ri;
    adv(wr, w_acc_last, w_wait, w_to);
    adv(rr, r_acc_last, r_wait, r_to);
  endtask

  task automatic idle_step(input logic [63:0] rdat, input logic [1:0] rrsp);
    step(0, 32'h0, 0, 32'h0, 2'b00, 2'b00, rdat, rrsp);
  endtask

  initial begin
    bit wr_q, rr_q;
    logic [31:0] wa_q, ra_q;
    base_tab[0] = 4'h0;
    base_tab[1] = 4'hC;
    model_reset();
    resetb = 1'b0;
    idle_inputs();
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    resetb = 1'b1;

    // Single read to slave 1, data returned next cycle.
    step(0, 32'h0, 1, 32'hC000_0004, 2'b00, 2'b10, 64'h0, 2'b00);
    chk("t1.m_rvalid", 32'(m_rvalid), 32'(1));
    chk("t1.s_rready", 32'(s_rready), 32'(2'b10));
    idle_step({32'h0000_1234, 32'h0}, 2'b10);
    chk("t1.m_rdata", m_rdata, 32'h0000_1234);
    chk("t1.m_rresp", 32'(m_rresp), 32'(1));

    // Back-to-back reads to different slaves.
    step(0, 32'h0, 1, 32'h0000_0010, 2'b00, 2'b01, 64'h0, 2'b11);
    step(0, 32'h0, 1, 32'hC000_0000, 2'b00, 2'b10, {32'h0, 32'hA}, 2'b11);
    chk("t2.first", m_rdata, 32'hA);
    idle_step({32'hB, 32'h0}, 2'b11);
    chk("t2.second", m_rdata, 32'hB);

    // Write decode miss.
    step(1, 32'h5000_0000, 0, 32'h0, 2'b11, 2'b00, 64'h0, 2'b00);
    chk("t3.m_wvalid", 32'(m_wvalid), 32'(1));
    chk("t3.s_wready", 32'(s_wready), 32'(0));
    idle_step(64'h0, 2'b00);
    chk("t3.err", 32'(err), 32'(1));
`ifdef DMEM_ROUTER_ERR_CAPTURE_EN
    chk("t3.err_cause", 32'(err_cause), 32'(1));
    chk("t3.err_addr", err_addr, 32'h5000_0000);
`endif

    // Read timeout: slave 0 never answers.
    for (int i = 1; i <= 5; i++) begin
      step(0, 32'h0, 1, 32'h0000_0000, 2'b00, 2'b00, 64'h0, 2'b11);
      chk($sformatf("t4.m_rvalid%0d", i), 32'(m_rvalid), 32'(i == 5));
    end
    chk("t4.s_rready", 32'(s_rready), 32'(0));
    idle_step(64'h0, 2'b11);
    chk("t4.m_rdata", m_rdata, ERR_DATA);
    chk("t4.m_rresp", 32'(m_rresp), 32'(0));
    chk("t4.err", 32'(err), 32'(1));
`ifdef DMEM_ROUTER_ERR_CAPTURE_EN
    chk("t4.err_cause", 32'(err_cause), 32'(3));
`endif

    // Simultaneous write and read misses: one pulse, write captured.
    step(1, 32'h5000_0000, 1, 32'h7000_0000, 2'b00, 2'b00, 64'h0, 2'b00);
    idle_step(64'h0, 2'b00);
    chk("t5.err", 32'(err), 32'(1));
`ifdef DMEM_ROUTER_ERR_CAPTURE_EN
    chk("t5.err_cause", 32'(err_cause), 32'(1));
    chk("t5.err_addr", err_addr, 32'h5000_0000);
`endif
    idle_step(64'h0, 2'b00);
    chk("t5.single_pulse", 32'(err), 32'(0));

    // Reset while a read waits and an error pulse is pending.
    step(1, 32'h9000_0000, 1, 32'h0000_0000, 2'b00, 2'b00, 64'h0, 2'b00);
    step(0, 32'h0, 1, 32'h0000_0000, 2'b00, 2'b00, 64'h0, 2'b00);
    resetb = 1'b0;
    idle_inputs();
    #1;
    chk_reset_vals("midreset");
    model_reset();
    @(negedge clk);
    resetb = 1'b1;
    step(0, 32'h0, 1, 32'hC000_0000, 2'b00, 2'b10, 64'h0, 2'b00);
    idle_step({32'h0000_0055, 32'h0}, 2'b10);
    chk("t6.m_rdata", m_rdata, 32'h0000_0055);

    // Randomized traffic against the model.
    wr_q = 0; rr_q = 0; wa_q = 0; ra_q = 0;
    for (int n = 0; n < 1500; n++) begin
      logic [1:0] swv, srv;
      if (!wr_q || w_acc_last || $urandom_range(0, 7) == 0) begin
        wr_q = ($urandom_range(0, 3) != 0); wa_q = rand_addr();
      end
      if (!rr_q || r_acc_last || $urandom_range(0, 7) == 0) begin
        rr_q = ($urandom_range(0, 3) != 0); ra_q = rand_addr();
      end
      for (int b = 0; b < 2; b++) begin
        swv[b] = ($urandom_range(0, 2) == 0);
        srv[b] = ($urandom_range(0, 2) == 0);
      end
      step(wr_q, wa_q, rr_q, ra_q, swv, srv, {$urandom, $urandom}, 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_router.md
Name: dmem_router

Overview:
- Parametrised data-side interconnect between the core's split read/write data port and NSLV slave ports (data RAM, CLINT, future MMIO peripherals).
- Generalises the fixed two-way RAM/MMIO split to NSLV address-decoded regions.
- Adds a registered read-return select that changes only on accepted requests.
- Adds a decode-miss responder and per-channel timeout recovery with error reporting.

Parameters:
- NSLV, 2, number of slave ports (1..8).
- DEC_HI, 31, MSB of the address decode field.
- DEC_LO, 28, LSB of the address decode field.
- SLV_BASE, {4'hC,4'h0}, packed NSLV x (DEC_HI-DEC_LO+1) decode values; slave i matches when addr[DEC_HI:DEC_LO]==SLV_BASE[i]; lowest index wins on overlap.
- TIMEOUT, 255, cycles a request may wait for valid before forced completion; 0 disables.
- ERR_DATA, 32'hDEADBEEF, read data returned on miss or timeout.

Ports:
- clk  in  1  clock
- resetb  in  1  asynchronous active-low reset
- m_wready  in  1  master write request
- m_wvalid  out  1  write accepted
- m_waddr  in  32  write address
- m_wdata  in  32  write data
- m_wstrb  in  4  byte strobes
- m_rready  in  1  master read request
- m_rvalid  out  1  read accepted
- m_raddr  in  32  read address
- m_rresp  out  1  1=OK, 0=error; valid in the data cycle
- m_rdata  out  32  read data; valid in the cycle after acceptance
- s_wready  out  NSLV  per-slave write request
- s_wvalid  in  NSLV  per-slave write accept
- s_waddr / s_wdata / s_wstrb  out  32/32/4  broadcast to all slaves
- s_rready  out  NSLV  per-slave read request
- s_rvalid  in  NSLV  per-slave read accept
- s_raddr  out  32  broadcast
- s_rresp  in  NSLV  per-slave response
- s_rdata  in  NSLV*32  packed slave data
- err  out  1  one-cycle pulse on miss or timeout
- err_addr  out  32  address of the last error
- err_cause  out  2  0=none, 1=write miss, 2=read miss, 3=timeout

Behaviour:
- Reset: m_wvalid=0, m_rvalid=0, m_rresp=1, m_rdata=0, s_wready=0, s_rready=0, err=0, err_addr=0, err_cause=0. Both FSMs reset to IDLE; select register reset to NSLV (no slave).
- Handshake: a transfer completes in the cycle where request and valid are both high. Read data and response are presented exactly 1 cycle after acceptance.
- Request routing: s_wready[i] = m_wready & whit[i] & (wstate!=TOUT). s_rready[i] is defined the same way for reads.
- Valid return: m_wvalid and m_rvalid are the selected slave's valid, combinational.
- Read select: rsel_q <= hit index (NSLV on miss) only on read acceptance; otherwise held. m_rdata and m_rresp are muxed from rsel_q. When rsel_q==NSLV, m_rdata=ERR_DATA and m_rresp=0.
- Per-channel FSM (write and read are independent): IDLE -> WAIT on request. WAIT -> IDLE on accept. WAIT -> TOUT when the counter reaches TIMEOUT. TOUT forces valid=1 for exactly 1 cycle, suppresses s_*ready that cycle, then returns to IDLE.
- Counter: 8..16 bits, sized by $clog2(TIMEOUT+1). Clears on accept or on request deassert.
- Decode miss: the router asserts valid in the same cycle (0 wait), drops writes, and returns ERR_DATA/rresp=0 for reads.
- err: pulses the cycle after any miss or timeout. If write and read errors occur in the same cycle, one pulse is issued and the write error is captured.
- Request withdrawn mid-WAIT: the FSM returns to IDLE with no error.
- Reset mid-operation: all state clears; no pending response is replayed.
- Back-to-back reads to different slaves: the select switches each accepted cycle, so data always pairs with the correct slave.

Optional Feature:
- DMEM_ROUTER_ERR_CAPTURE_EN defined: err_addr and err_cause latch on each error; they are sticky until the next error.
- Undefined: err_addr=0 and err_cause=0 constantly; err still pulses.

Decomposition:
- Shared package/include (alongside opcode.vh): err_cause encodings, FSM state encodings (IDLE=0, WAIT=1, TOUT=2), MMIO_BASE-style decode constants.
- One natural sub-module, dmem_router_chan: decode, FSM and timeout counter for a single direction. Instantiate it twice; the read instance additionally owns rsel_q.

Test Plan:
- NSLV=2, read 0xC000_0004 with slave1 rvalid=1 and rdata=0x1234 -> m_rvalid same cycle; next cycle m_rdata=0x1234, m_rresp=1; s_rready=2'b10.
- Alternating reads to 0x0000_0010 (slave0 data 0xA) and 0xC000_0000 (slave1 data 0xB) on consecutive cycles -> m_rdata sequence 0xA, 0xB with no mixing.
- Write to 0x5000_0000 (no match) -> m_wvalid=1 same cycle, s_wready=0, err pulse next cycle, err_cause=1, err_addr=0x5000_0000 (macro on).
- TIMEOUT=4, read slave0 held with s_rvalid=0 -> m_rvalid forced on the 5th cycle, then m_rdata=0xDEADBEEF, m_rresp=0, err_cause=3.
- Read miss and write miss in the same cycle -> single err pulse, err_cause=1.
- Assert resetb=0 during WAIT -> all outputs return to reset values asynchronously; after release, a new read completes normally.
